// File: rtl/ristretto_instruction_fetch_unit_if.sv
// Instruction-memory bus between the ristretto fetch unit and imem.
// The fetch unit uses the master modport; the memory side uses slave.
interface ristretto_instruction_fetch_unit_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 ifu_imem_req_o;
  logic [AddrWidth-1:0] ifu_imem_addr_o;
  logic                 ifu_imem_gnt_i;
  logic                 ifu_imem_rvalid_i;
  logic [DataWidth-1:0] ifu_imem_rdata_i;

  modport master (
    output ifu_imem_req_o,
    output ifu_imem_addr_o,
    input  ifu_imem_gnt_i,
    input  ifu_imem_rvalid_i,
    input  ifu_imem_rdata_i
  );

  modport slave (
    input  ifu_imem_req_o,
    input  ifu_imem_addr_o,
    output ifu_imem_gnt_i,
    output ifu_imem_rvalid_i,
    output ifu_imem_rdata_i
  );
endinterface

// File: rtl/ristretto_instruction_fetch_unit.sv
// ristretto fetch stage: one req/gnt/rvalid transaction per fetch_en, with flush squashing.
// Optional misaligned-fetch trap via RISTRETTO_IFU_MISALIGN_TRAP_EN.
module ristretto_instruction_fetch_unit #(
  parameter int                   DataWidth = 32,
  parameter int                   AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BootAddr  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ifu_fetch_en_i,
  output logic                 ifu_busy_o,
  input  logic                 ifu_flush_i,
  input  logic [AddrWidth-1:0] ifu_redirect_pc_i,
  ristretto_instruction_fetch_unit_if.master imem,
  output logic [DataWidth-1:0] ifu_instr_o,
  output logic [AddrWidth-1:0] ifu_pc_o,
  output logic                 ifu_valid_o
`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
  ,output logic                ifu_misalign_o
`endif
);

  localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AddrWidth-1:0] r_pc;
  logic [DataWidth-1:0] r_instr;
  logic [AddrWidth-1:0] r_pc_o;
  logic                 r_valid;
  logic [AddrWidth-1:0] w_redirect;
  logic                 w_busy;
  logic                 w_req;
  logic                 w_deliver;
  logic                 w_mis_fire;
  logic                 w_mis_block;

`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
  logic r_misalign;
  logic r_mis_hold;
  assign w_redirect  = ifu_redirect_pc_i;
  assign w_mis_block = (r_pc[1:0] != 2'b00);
`else
  assign w_redirect  = ifu_redirect_pc_i & ~AddrWidth'(3);
  assign w_mis_block = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (!ifu_flush_i && ifu_fetch_en_i && !w_mis_block)
          w_state_nxt = REQ;
      end
      REQ: begin
        // a grant seen alongside a flush still owes us a response
        if (ifu_flush_i)
          w_state_nxt = imem.ifu_imem_gnt_i ? DROP : IDLE;
        else if (imem.ifu_imem_gnt_i)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem.ifu_imem_rvalid_i) w_state_nxt = IDLE;
        else if (ifu_flush_i)       w_state_nxt = DROP;
      end
      DROP: begin
        if (imem.ifu_imem_rvalid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != IDLE);
    w_req      = (r_state == REQ);
    w_deliver  = (r_state == WAIT) && imem.ifu_imem_rvalid_i
                 && !ifu_flush_i;
`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
    w_mis_fire = (r_state == IDLE) && ifu_fetch_en_i && !ifu_flush_i
                 && w_mis_block && !r_mis_hold;
`else
    w_mis_fire = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc    <= BootAddr;
      r_instr <= Nop;
      r_pc_o  <= BootAddr;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_deliver | w_mis_fire;
      if (ifu_flush_i)    r_pc <= w_redirect;
      else if (w_deliver) r_pc <= r_pc + AddrWidth'(4);
      if (w_deliver) begin
        r_instr <= imem.ifu_imem_rdata_i;
        r_pc_o  <= r_pc;
      end else if (w_mis_fire) begin
        r_instr <= Nop;
        r_pc_o  <= r_pc;
      end
    end
  end

`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_misalign <= 1'b0;
      r_mis_hold <= 1'b0;
    end else begin
      r_misalign <= w_mis_fire;
      if (ifu_flush_i)     r_mis_hold <= 1'b0;
      else if (w_mis_fire) r_mis_hold <= 1'b1;
    end
  end
  assign ifu_misalign_o = r_misalign;
`endif

  assign ifu_busy_o           = w_busy;
  assign imem.ifu_imem_req_o  = w_req;
  assign imem.ifu_imem_addr_o = r_pc;
  assign ifu_instr_o          = r_instr;
  assign ifu_pc_o             = r_pc_o;
  assign ifu_valid_o          = r_valid;

endmodule

// File: tb/tb_ristretto_instruction_fetch_unit.sv
// Directed bench for ristretto_instruction_fetch_unit.
// Inputs change on negedge; outputs are checked on negedge.
module tb_ristretto_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        flush;
  logic [31:0] redirect;
  logic        busy;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic        valid;
`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ristretto_instruction_fetch_unit_if #(.DataWidth(32), .AddrWidth(32)) imem ();

  ristretto_instruction_fetch_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ifu_fetch_en_i    (fetch_en),
    .ifu_busy_o        (busy),
    .ifu_flush_i       (flush),
    .ifu_redirect_pc_i (redirect),
    .imem              (imem.master),
    .ifu_instr_o       (instr),
    .ifu_pc_o          (pc_o),
    .ifu_valid_o       (valid)
`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
    ,.ifu_misalign_o   (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a,
                          input int gdly, input logic [31:0] d);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      chk({tag, "_req_hold"}, imem.ifu_imem_req_o, 1);
      chk({tag, "_addr_hold"}, imem.ifu_imem_addr_o, a);
      step();
    end
    chk({tag, "_req"}, imem.ifu_imem_req_o, 1);
    chk({tag, "_addr"}, imem.ifu_imem_addr_o, a);
    imem.ifu_imem_gnt_i = 1'b1;
    step();
    imem.ifu_imem_gnt_i   = 1'b0;
    chk({tag, "_req_drop"}, imem.ifu_imem_req_o, 0);
    imem.ifu_imem_rvalid_i = 1'b1;
    imem.ifu_imem_rdata_i  = d;
    step();
    imem.ifu_imem_rvalid_i = 1'b0;
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_instr"}, instr, d);
    chk({tag, "_pc"}, pc_o, a);
    chk({tag, "_busy"}, busy, 0);
    step();
    chk({tag, "_valid_1cyc"}, valid, 0);
    chk({tag, "_instr_hold"}, instr, d);
    chk({tag, "_noreq"}, imem.ifu_imem_req_o, 0);
  endtask

  task automatic redirect_idle(input logic [31:0] a);
    flush    = 1'b1;
    redirect = a;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    flush = 1'b0;
    redirect = '0;
    imem.ifu_imem_gnt_i = 1'b0;
    imem.ifu_imem_rvalid_i = 1'b0;
    imem.ifu_imem_rdata_i = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_req", imem.ifu_imem_req_o, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc_o, 0);
    chk("rst_addr", imem.ifu_imem_addr_o, 0);
    rst = 1'b0;
    step();

    do_fetch("f0", 32'h0, 0, 32'h00A0_0093);
    chk("f0_next_addr", imem.ifu_imem_addr_o, 32'h4);
    do_fetch("f1", 32'h4, 3, 32'h1234_5678);

    // flush in WAIT, response two cycles later
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    imem.ifu_imem_gnt_i = 1'b1;
    step();
    imem.ifu_imem_gnt_i = 1'b0;
    flush = 1'b1;
    redirect = 32'h100;
    step();
    flush = 1'b0;
    chk("fw_valid", valid, 0);
    chk("fw_busy", busy, 1);
    step();
    imem.ifu_imem_rvalid_i = 1'b1;
    imem.ifu_imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem.ifu_imem_rvalid_i = 1'b0;
    chk("fw_drop_valid", valid, 0);
    chk("fw_idle", busy, 0);
    step();
    chk("fw_drop_valid2", valid, 0);
    do_fetch("f100", 32'h100, 0, 32'h0000_0033);

    // flush with same-cycle rvalid
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    imem.ifu_imem_gnt_i = 1'b1;
    step();
    imem.ifu_imem_gnt_i = 1'b0;
    flush = 1'b1;
    redirect = 32'h200;
    imem.ifu_imem_rvalid_i = 1'b1;
    step();
    flush = 1'b0;
    imem.ifu_imem_rvalid_i = 1'b0;
    chk("fr_valid", valid, 0);
    chk("fr_idle", busy, 0);
    chk("fr_instr_hold", instr, 32'h0000_0033);
    do_fetch("f200", 32'h200, 1, 32'h0010_0073);

    // flush in REQ with same-cycle gnt -> DROP
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    imem.ifu_imem_gnt_i = 1'b1;
    flush = 1'b1;
    redirect = 32'h300;
    step();
    imem.ifu_imem_gnt_i = 1'b0;
    flush = 1'b0;
    chk("fg_drop_busy", busy, 1);
    chk("fg_drop_req", imem.ifu_imem_req_o, 0);
    imem.ifu_imem_rvalid_i = 1'b1;
    step();
    imem.ifu_imem_rvalid_i = 1'b0;
    chk("fg_valid", valid, 0);
    chk("fg_idle", busy, 0);
    chk("fg_addr", imem.ifu_imem_addr_o, 32'h300);

    // PC wrap
    redirect_idle(32'hFFFF_FFFC);
    do_fetch("fwrap", 32'hFFFF_FFFC, 0, 32'h0000_0013);
    chk("wrap_addr", imem.ifu_imem_addr_o, 32'h0);

    // misaligned redirect
    redirect_idle(32'h102);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
`ifdef RISTRETTO_IFU_MISALIGN_TRAP_EN
    chk("mis_noreq", imem.ifu_imem_req_o, 0);
    chk("mis_valid", valid, 1);
    chk("mis_flag", misalign, 1);
    chk("mis_pc", pc_o, 32'h102);
    chk("mis_instr", instr, 32'h0000_0013);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("mis_hold_valid", valid, 0);
    chk("mis_hold_flag", misalign, 0);
    chk("mis_hold_req", imem.ifu_imem_req_o, 0);
    redirect_idle(32'h100);
`else
    chk("mis_req", imem.ifu_imem_req_o, 1);
    chk("mis_addr", imem.ifu_imem_addr_o, 32'h100);
    imem.ifu_imem_gnt_i = 1'b1;
    step();
    imem.ifu_imem_gnt_i = 1'b0;
    imem.ifu_imem_rvalid_i = 1'b1;
    imem.ifu_imem_rdata_i = 32'h0000_0093;
    step();
    imem.ifu_imem_rvalid_i = 1'b0;
    chk("mis_pc", pc_o, 32'h100);
    step();
    redirect_idle(32'h100);
`endif

    // reset in WAIT, late rvalid ignored
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    imem.ifu_imem_gnt_i = 1'b1;
    step();
    imem.ifu_imem_gnt_i = 1'b0;
    chk("rw_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_req", imem.ifu_imem_req_o, 0);
    chk("rw_instr", instr, 32'h0000_0013);
    chk("rw_pc", pc_o, 0);
    chk("rw_addr", imem.ifu_imem_addr_o, 0);
    step();
    rst = 1'b0;
    imem.ifu_imem_rvalid_i = 1'b1;
    imem.ifu_imem_rdata_i = 32'hBAD0_BAD0;
    step();
    imem.ifu_imem_rvalid_i = 1'b0;
    chk("rw_late_valid", valid, 0);
    chk("rw_late_busy", busy, 0);
    chk("rw_late_instr", instr, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
